spi_tx_byte_fifo: RTL

Byte FIFO between the register read-out stage and the SPI slave transmit shifter. It absorbs bursts of up to four bytes that the read-out stage pushes on consecutive clocks with no backpressure. It returns one byte per SPI request, so the shifter can pull bytes at its own rate. It also reports occupancy and keeps sticky overflow and underflow error flags.

---
 rtl/spi_tx_byte_fifo.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_tx_byte_fifo.sv
// Byte FIFO feeding the SPI slave transmit shifter, one byte per tx_req.
// TX_FIFO_UNDERFLOW_FILL_EN: empty requests return FILL_BYTE and set underflow.
module spi_tx_byte_fifo #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic                  sysClk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_in_valid,
  input  logic                  tx_req,
  output logic [7:0]            tx_byte,
  output logic                  tx_byte_valid,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_ereq;
  logic w_ovf_set;
  logic w_unf_set;
  logic [DEPTH_LOG2:0] w_cnt_nxt;

  // Decisions use the registered flags, i.e. occupancy before the edge.
  assign w_pop     = tx_req & ~fifo_empty;
  assign w_push    = byte_in_valid & (~fifo_full | w_pop);
  assign w_drop    = byte_in_valid & fifo_full & ~w_pop;
  assign w_ereq    = tx_req & fifo_empty;
  assign w_ovf_set = w_drop & ~flush;

`ifdef TX_FIFO_UNDERFLOW_FILL_EN
  assign w_unf_set = w_ereq & ~flush;
`else
  assign w_unf_set = 1'b0;
`endif

  always_comb begin
    w_cnt_nxt = fifo_count;
    unique case (1'b1)
      (w_push & ~w_pop): w_cnt_nxt = fifo_count + CNT_ONE;
      (w_pop & ~w_push): w_cnt_nxt = fifo_count - CNT_ONE;
      default:           w_cnt_nxt = fifo_count;
    endcase
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge sysClk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= byte_in;
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      tx_byte       <= 8'h00;
      tx_byte_valid <= 1'b0;
    end else if (flush) begin
      tx_byte_valid <= 1'b0;
    end else if (w_pop) begin
      tx_byte       <= r_mem[r_rd_ptr];
      tx_byte_valid <= 1'b1;
`ifdef TX_FIFO_UNDERFLOW_FILL_EN
    end else if (w_ereq) begin
      tx_byte       <= FILL_BYTE;
      tx_byte_valid <= 1'b1;
`endif
    end else begin
      tx_byte_valid <= 1'b0;
    end
  end

  // A fresh error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~err_clr) | w_ovf_set;
      underflow <= (underflow & ~err_clr) | w_unf_set;
    end
  end

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      fifo_count <= w_cnt_nxt;
      unique case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_state    <= S_PARTIAL;
            fifo_empty <= 1'b0;
          end
        end
        S_PARTIAL: begin
          if (w_pop && !w_push && fifo_count == CNT_ONE) begin
            r_state    <= S_EMPTY;
            fifo_empty <= 1'b1;
          end else if (w_push && !w_pop && fifo_count == CNT_LAST) begin
            r_state   <= S_FULL;
            fifo_full <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_pop && !w_push) begin
            r_state   <= S_PARTIAL;
            fifo_full <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          fifo_count <= '0;
          fifo_empty <= 1'b1;
          fifo_full  <= 1'b0;
        end
      endcase
    end
  end

endmodule
